// File: rtl/vga_pkg.sv
// Shared timing defaults, axis-total helpers and test-pattern colours for the VGA raster
// generator and its helpers.
package vga_pkg;

    // 640x480@60 defaults
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FRONT  = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BACK   = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FRONT  = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BACK   = 33;

    // RRRGGGBB bar colours
    localparam logic [7:0] RGB_WHITE   = 8'hFF;
    localparam logic [7:0] RGB_YELLOW  = 8'hFC;
    localparam logic [7:0] RGB_CYAN    = 8'h1F;
    localparam logic [7:0] RGB_GREEN   = 8'h1C;
    localparam logic [7:0] RGB_MAGENTA = 8'hE3;
    localparam logic [7:0] RGB_RED     = 8'hE0;
    localparam logic [7:0] RGB_BLUE    = 8'h03;
    localparam logic [7:0] RGB_BLACK   = 8'h00;

    function automatic int unsigned axis_total(input int unsigned active, input int unsigned front,
                                               input int unsigned sync, input int unsigned back);
        return active + front + sync + back;
    endfunction

    // Bits needed to hold the values 0..value-1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned bits;
        bits = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) bits = 32'(i + 1);
        end
        return bits;
    endfunction

    function automatic logic [7:0] bar_colour(input int unsigned idx);
        case (idx)
            0:       return RGB_WHITE;
            1:       return RGB_YELLOW;
            2:       return RGB_CYAN;
            3:       return RGB_GREEN;
            4:       return RGB_MAGENTA;
            5:       return RGB_RED;
            6:       return RGB_BLUE;
            default: return RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: enabled wrap counter with terminal-count flag, plus active and sync-window
// decodes of the next count so the parent can register them in step with the counter.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned W          = 10,
    parameter int unsigned TOTAL      = 800,
    parameter int unsigned ACTIVE     = 640,
    parameter int unsigned SYNC_START = 656,
    parameter int unsigned SYNC_LEN   = 96
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic [W-1:0] count_next_o,
    output logic         tc_o,
    output logic         active_next_o,
    output logic         sync_next_o
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    logic [W-1:0] count_q, count_d;

    assign tc_o = (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = tc_o ? '0 : count_q + W'(1);
        end
    end

    // Reset parks on the last count so the first enable lands on 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= LAST;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o       = count_q;
    assign count_next_o  = count_d;
    assign active_next_o = (32'(count_d) < ACTIVE);
    assign sync_next_o   = (32'(count_d) >= SYNC_START) && (32'(count_d) < SYNC_START + SYNC_LEN);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator advancing on a pixel-enable qualifier.
// Define VGA_TEST_PATTERN_EN to add the out_rgb colour-bar test pattern.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned X_W       = 10,
    parameter int unsigned Y_W       = 10
) (
    input  logic           in_VGA_clock,
    input  logic           in_reset_n,
    input  logic           in_pixel_en,
    output logic [X_W-1:0] out_pixelX,
    output logic [Y_W-1:0] out_pixelY,
    output logic [X_W-1:0] out_hCount,
    output logic [Y_W-1:0] out_vCount,
    output logic           out_hSync,
    output logic           out_vSync,
    output logic           out_active,
    output logic           out_lineStart,
    output logic           out_frameStart
`ifdef VGA_TEST_PATTERN_EN
    ,
    output logic [7:0]     out_rgb
`endif
);

    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

    if (X_W < clog2(H_TOTAL) || Y_W < clog2(V_TOTAL)) begin : g_width_check
        $error("vga_timing_gen: X_W/Y_W too narrow for the configured totals");
    end

    logic [X_W-1:0] h_next;
    logic [Y_W-1:0] v_next;
    logic h_tc, v_tc, h_act_d, v_act_d, h_sync_d, v_sync_d;
    logic active_d, line_d, frame_d;

    logic [X_W-1:0] pix_x_q;
    logic [Y_W-1:0] pix_y_q;
    logic hsync_q, vsync_q, active_q, line_q, frame_q;

    vga_axis_counter #(
        .W          (X_W),
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_ACTIVE + H_FRONT),
        .SYNC_LEN   (H_SYNC)
    ) u_h_counter (
        .clk_i         (in_VGA_clock),
        .rst_ni        (in_reset_n),
        .en_i          (in_pixel_en),
        .count_o       (out_hCount),
        .count_next_o  (h_next),
        .tc_o          (h_tc),
        .active_next_o (h_act_d),
        .sync_next_o   (h_sync_d)
    );

    vga_axis_counter #(
        .W          (Y_W),
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_ACTIVE + V_FRONT),
        .SYNC_LEN   (V_SYNC)
    ) u_v_counter (
        .clk_i         (in_VGA_clock),
        .rst_ni        (in_reset_n),
        .en_i          (in_pixel_en & h_tc),
        .count_o       (out_vCount),
        .count_next_o  (v_next),
        .tc_o          (v_tc),
        .active_next_o (v_act_d),
        .sync_next_o   (v_sync_d)
    );

    assign active_d = h_act_d & v_act_d;
    assign line_d   = in_pixel_en & h_tc;
    assign frame_d  = line_d & v_tc;

    // Everything registers from the next counts, so outputs line up with out_hCount/out_vCount.
    always_ff @(posedge in_VGA_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            hsync_q  <= ~HSYNC_POL;
            vsync_q  <= ~VSYNC_POL;
            active_q <= 1'b0;
            pix_x_q  <= '0;
            pix_y_q  <= '0;
            line_q   <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            hsync_q  <= h_sync_d ? HSYNC_POL : ~HSYNC_POL;
            vsync_q  <= v_sync_d ? VSYNC_POL : ~VSYNC_POL;
            active_q <= active_d;
            pix_x_q  <= active_d ? h_next : '0;
            pix_y_q  <= active_d ? v_next : '0;
            line_q   <= line_d;
            frame_q  <= frame_d;
        end
    end

    assign out_hSync      = hsync_q;
    assign out_vSync      = vsync_q;
    assign out_active     = active_q;
    assign out_pixelX     = pix_x_q;
    assign out_pixelY     = pix_y_q;
    assign out_lineStart  = line_q;
    assign out_frameStart = frame_q;

`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned BAR_W = H_ACTIVE / 8;

    logic [7:0] rgb_d, rgb_q;

    // Columns past the eighth bar fall through to black.
    always_comb begin
        rgb_d = RGB_BLACK;
        for (int unsigned i = 0; i < 8; i++) begin
            if (32'(h_next) >= i * BAR_W && 32'(h_next) < (i + 1) * BAR_W) begin
                rgb_d = bar_colour(i);
            end
        end
        if (!active_d) rgb_d = '0;
    end

    always_ff @(posedge in_VGA_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign out_rgb = rgb_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance and a tiny mode instance, both checked
// every clock against a position-based raster model.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n = 1'b1, en_a = 1'b0;
    logic rst_b_n = 1'b1, en_b = 1'b0;

    logic [9:0] a_x, a_y, a_h, a_v;
    logic       a_hs, a_vs, a_act, a_ls, a_fs;
    logic [3:0] b_x, b_h;
    logic [2:0] b_y, b_v;
    logic       b_hs, b_vs, b_act, b_ls, b_fs;
`ifdef VGA_TEST_PATTERN_EN
    logic [7:0] a_rgb, b_rgb;
`endif

    vga_timing_gen dut_a (
        .in_VGA_clock   (clk),
        .in_reset_n     (rst_a_n),
        .in_pixel_en    (en_a),
        .out_pixelX     (a_x),
        .out_pixelY     (a_y),
        .out_hCount     (a_h),
        .out_vCount     (a_v),
        .out_hSync      (a_hs),
        .out_vSync      (a_vs),
        .out_active     (a_act),
        .out_lineStart  (a_ls),
        .out_frameStart (a_fs)
`ifdef VGA_TEST_PATTERN_EN
        ,
        .out_rgb        (a_rgb)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE (8), .H_FRONT (2), .H_SYNC (2), .H_BACK (2),
        .V_ACTIVE (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
        .HSYNC_POL (1'b1), .VSYNC_POL (1'b0), .X_W (4), .Y_W (3)
    ) dut_b (
        .in_VGA_clock   (clk),
        .in_reset_n     (rst_b_n),
        .in_pixel_en    (en_b),
        .out_pixelX     (b_x),
        .out_pixelY     (b_y),
        .out_hCount     (b_h),
        .out_vCount     (b_v),
        .out_hSync      (b_hs),
        .out_vSync      (b_vs),
        .out_active     (b_act),
        .out_lineStart  (b_ls),
        .out_frameStart (b_fs)
`ifdef VGA_TEST_PATTERN_EN
        ,
        .out_rgb        (b_rgb)
`endif
    );

    typedef struct packed {
        logic [9:0] h, v, x, y;
        logic       hs, vs, act, ls, fs;
    } vis_t;

    int vectors = 0;
    int miscompares = 0;
    int n_a = 0, n_b = 0;   // enabled clocks since reset
    bit last_en_a = 1'b0, last_en_b = 1'b0;

    // Raster position is simply (n-1) mod frame size; everything else follows from it.
    function automatic vis_t model(input int n, input bit en,
                                   input int ha, input int hf, input int hsw, input int hb,
                                   input int va, input int vf, input int vsw, input int vb,
                                   input bit hp, input bit vp);
        vis_t r;
        int ht, vt, pos, h, v;
        bit act;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        if (n == 0) begin
            h = ht - 1;
            v = vt - 1;
        end else begin
            pos = (n - 1) % (ht * vt);
            h   = pos % ht;
            v   = pos / ht;
        end
        act   = (h < ha) && (v < va);
        r.h   = 10'(h);
        r.v   = 10'(v);
        r.x   = act ? 10'(h) : 10'd0;
        r.y   = act ? 10'(v) : 10'd0;
        r.hs  = (h >= ha + hf && h < ha + hf + hsw) ? hp : ~hp;
        r.vs  = (v >= va + vf && v < va + vf + vsw) ? vp : ~vp;
        r.act = act;
        r.ls  = en && (n > 0) && (h == 0);
        r.fs  = r.ls && (v == 0);
        return r;
    endfunction

    function automatic vis_t exp_a();
        return model(n_a, last_en_a, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
    endfunction

    function automatic vis_t exp_b();
        return model(n_b, last_en_b, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b0);
    endfunction

    function automatic vis_t obs_a();
        vis_t r;
        r.h = a_h; r.v = a_v; r.x = a_x; r.y = a_y;
        r.hs = a_hs; r.vs = a_vs; r.act = a_act; r.ls = a_ls; r.fs = a_fs;
        return r;
    endfunction

    function automatic vis_t obs_b();
        vis_t r;
        r.h = 10'(b_h); r.v = 10'(b_v); r.x = 10'(b_x); r.y = 10'(b_y);
        r.hs = b_hs; r.vs = b_vs; r.act = b_act; r.ls = b_ls; r.fs = b_fs;
        return r;
    endfunction

    task automatic tick_a(input bit en);
        en_a = en;
        @(posedge clk);
        #1;
        last_en_a = en && rst_a_n;
        if (last_en_a) n_a++;
    endtask

    task automatic tick_b(input bit en);
        en_b = en;
        @(posedge clk);
        #1;
        last_en_b = en && rst_b_n;
        if (last_en_b) n_b++;
    endtask

    task automatic test_reset();
        #2;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        #2;
        vectors++;
        if (obs_a() !== exp_a()) begin
            miscompares++;
            $display("FAIL reset_a: got %h expected %h", obs_a(), exp_a());
        end
        vectors++;
        if (obs_b() !== exp_b()) begin
            miscompares++;
            $display("FAIL reset_b: got %h expected %h", obs_b(), exp_b());
        end
        tick_a(1'b1);
        vectors++;
        if (obs_a() !== exp_a()) begin
            miscompares++;
            $display("FAIL reset_held_a: got %h expected %h", obs_a(), exp_a());
        end
        #2;
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        tick_a(1'b1);
        vectors++;
        if (a_h !== 10'd0 || a_v !== 10'd0 || a_ls !== 1'b1 || a_fs !== 1'b1 || a_act !== 1'b1)
        begin
            miscompares++;
            $display("FAIL first_pixel: got h=%0d v=%0d ls=%b fs=%b act=%b expected 0 0 1 1 1",
                     a_h, a_v, a_ls, a_fs, a_act);
        end
        tick_a(1'b1);
        vectors++;
        if (a_h !== 10'd1 || a_ls !== 1'b0 || a_fs !== 1'b0) begin
            miscompares++;
            $display("FAIL second_pixel: got h=%0d ls=%b fs=%b expected 1 0 0", a_h, a_ls, a_fs);
        end
    endtask

    task automatic test_line();
        int hs_low = 0, first_low = -1, fell_at = -1;
        logic prev_act = 1'b1;
        for (int i = 0; i < 799; i++) begin
            tick_a(1'b1);
            vectors++;
            if (obs_a() !== exp_a()) begin
                miscompares++;
                $display("FAIL line_model: got %h expected %h", obs_a(), exp_a());
            end
            if (a_hs === 1'b0) begin
                hs_low++;
                if (first_low < 0) first_low = int'(a_h);
            end
            if (prev_act === 1'b1 && a_act === 1'b0 && fell_at < 0) fell_at = int'(a_h);
            prev_act = a_act;
        end
        vectors++;
        if (hs_low != 96 || first_low != 656) begin
            miscompares++;
            $display("FAIL hsync_window: got %0d clocks from %0d expected 96 from 656",
                     hs_low, first_low);
        end
        vectors++;
        if (fell_at != 640) begin
            miscompares++;
            $display("FAIL active_fall: got %0d expected 640", fell_at);
        end
        vectors++;
        if (a_h !== 10'd0 || a_v !== 10'd1) begin
            miscompares++;
            $display("FAIL line_wrap: got h=%0d v=%0d expected 0 1", a_h, a_v);
        end
    endtask

    task automatic test_pixel_en_pulsed();
        int pulses = 0, last_ls = -1;
        for (int i = 0; i < 3200; i++) begin
            tick_a((i % 4) == 3);
            vectors++;
            if (obs_a() !== exp_a()) begin
                miscompares++;
                $display("FAIL pulsed_model: got %h expected %h", obs_a(), exp_a());
            end
            if (a_ls === 1'b1) begin
                pulses++;
                last_ls = i;
            end
        end
        vectors++;
        if (pulses != 1 || last_ls != 3199 || a_v !== 10'd2) begin
            miscompares++;
            $display("FAIL pulsed_line: got %0d strobes last at %0d v=%0d expected 1 at 3199 v=2",
                     pulses, last_ls, a_v);
        end
    endtask

    task automatic test_random_en();
        for (int i = 0; i < 3000; i++) begin
            tick_a(1'($urandom_range(0, 1)));
            vectors++;
            if (obs_a() !== exp_a()) begin
                miscompares++;
                $display("FAIL random_en: got %h expected %h", obs_a(), exp_a());
            end
        end
    endtask

    task automatic test_reset_mid_line();
        int guard = 0;
        while (((n_a - 1) % 800) != 300 && guard < 1000) begin
            tick_a(1'b1);
            guard++;
        end
        vectors++;
        if (a_h !== 10'd300) begin
            miscompares++;
            $display("FAIL mid_line_reach: got h=%0d expected 300", a_h);
        end
        #3;
        rst_a_n = 1'b0;
        #1;
        n_a = 0;
        last_en_a = 1'b0;
        vectors++;
        if (obs_a() !== exp_a()) begin
            miscompares++;
            $display("FAIL async_reset: got %h expected %h", obs_a(), exp_a());
        end
        for (int i = 0; i < 3; i++) begin
            tick_a(1'($urandom_range(0, 1)));
            vectors++;
            if (obs_a() !== exp_a()) begin
                miscompares++;
                $display("FAIL reset_hold: got %h expected %h", obs_a(), exp_a());
            end
        end
        en_a = 1'b0;
        #2;
        rst_a_n = 1'b1;
        tick_a(1'b0);
        tick_a(1'b1);
        vectors++;
        if (obs_a() !== exp_a() || a_h !== 10'd0 || a_v !== 10'd0 || a_fs !== 1'b1) begin
            miscompares++;
            $display("FAIL restart: got %h expected %h", obs_a(), exp_a());
        end
    endtask

    task automatic test_small_mode();
        int last_fs = -1, hs_high = 0, vwraps = 0;
        logic [2:0] prev_v = 3'd6;
        for (int i = 0; i < 294; i++) begin
            tick_b(1'b1);
            vectors++;
            if (obs_b() !== exp_b()) begin
                miscompares++;
                $display("FAIL small_model: got %h expected %h", obs_b(), exp_b());
            end
            if (i < 98 && b_hs === 1'b1) hs_high++;
            if (prev_v === 3'd6 && b_v === 3'd0) vwraps++;
            prev_v = b_v;
            if (b_fs === 1'b1) begin
                if (last_fs >= 0) begin
                    vectors++;
                    if (i - last_fs != 98) begin
                        miscompares++;
                        $display("FAIL frame_period: got %0d expected 98", i - last_fs);
                    end
                end
                last_fs = i;
            end
        end
        vectors++;
        if (hs_high != 14 || vwraps != 3) begin
            miscompares++;
            $display("FAIL small_sync_wrap: got hs=%0d wraps=%0d expected 14 3", hs_high, vwraps);
        end
        for (int i = 0; i < 300; i++) begin
            tick_b(1'($urandom_range(0, 1)));
            vectors++;
            if (obs_b() !== exp_b()) begin
                miscompares++;
                $display("FAIL small_random: got %h expected %h", obs_b(), exp_b());
            end
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_pixel_en_pulsed();
        test_random_en();
        test_reset_mid_line();
        en_a = 1'b0;
        test_small_mode();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
